mmio_store_monitor: RTL and testbench

Bus-side observer that sits directly downstream of the multicycle ARM core's memory port, next to the unified memory. It samples every store (MemWrite, Adr, WriteData), queues stores that fall in a memory-mapped I/O window into a small FIFO drained over a valid/ready port, and latches a completion verdict when the program writes its result word to the "done" address. It gives the bench and any later host or UART logic one registered, cycle-exact view of the program's externally visible stores.

---
 rtl/mmio_mon_pkg.sv | 23 ++
 rtl/mmio_mon_fifo.sv | 51 +++++
 rtl/mmio_store_monitor.sv | 104 ++++++++++
 tb/tb_mmio_store_monitor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_mon_pkg.sv
// Shared types and defaults for the MMIO store monitor: window geometry,
// FIFO entry layout and the default window, done address and pass value.
package mmio_mon_pkg;

  localparam int WIN_BYTES = 32;
  localparam int OFF_W     = 3;
  localparam int DATA_W    = 32;

  localparam logic [31:0] DEF_MMIO_BASE = 32'h0000_0060;
  localparam logic [31:0] DEF_DONE_ADR  = 32'h0000_0064;
  localparam logic [31:0] DEF_EXPECT    = 32'h0000_0007;

  typedef struct packed {
    logic [OFF_W-1:0]  offset;
    logic [DATA_W-1:0] data;
  } mon_entry_t;

  // Word offset of a byte address inside the 32-byte window.
  function automatic logic [OFF_W-1:0] win_offset(input logic [31:0] adr);
    return adr[OFF_W+1:2];
  endfunction

endpackage

// File: rtl/mmio_mon_fifo.sv
// Synchronous FIFO of monitor entries; pointers carry one extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module mmio_mon_fifo
  import mmio_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  mon_entry_t i_push_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output mon_entry_t o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  mon_entry_t r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_head = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/mmio_store_monitor.sv
// Observes core stores, queues MMIO-window stores and latches the done/pass
// verdict. Define MMIO_MON_BYPASS_EN to present a store on an empty FIFO in
// the same cycle instead of one cycle later.
module mmio_store_monitor
  import mmio_mon_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
  parameter logic [31:0] DONE_ADR  = DEF_DONE_ADR,
  parameter logic [31:0] EXPECT    = DEF_EXPECT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_offset,
  output logic [31:0] out_data,
  output logic        done,
  output logic        pass,
  output logic        overflow,
  output logic [15:0] store_count
);

  logic       w_in_win;
  logic       w_is_done;
  logic       w_byp;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  mon_entry_t w_new;
  mon_entry_t w_head;

  logic        r_done;
  logic        r_pass;
  logic        r_overflow;
  logic [15:0] r_count;

  assign w_in_win  = MemWrite && (Adr[31:5] == MMIO_BASE[31:5]) && (Adr[1:0] == 2'b00);
  assign w_is_done = MemWrite && (Adr == DONE_ADR);
  assign w_new     = '{offset: win_offset(Adr), data: WriteData};

`ifdef MMIO_MON_BYPASS_EN
  assign w_byp = w_in_win & w_empty;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed store taken by the consumer never touches the FIFO.
  assign w_push = w_in_win & ~(w_byp & out_ready);
  assign w_pop  = out_ready & ~w_empty;

  mmio_mon_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_push      (w_push),
    .i_push_data (w_new),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  assign out_valid = ~w_empty | w_byp;

  always_comb begin
    out_offset = '0;
    out_data   = '0;
    if (!w_empty) begin
      out_offset = w_head.offset;
      out_data   = w_head.data;
    end else if (w_byp) begin
      out_offset = w_new.offset;
      out_data   = w_new.data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_overflow <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_is_done && !r_done) begin
        r_done <= 1'b1;
        r_pass <= (WriteData == EXPECT);
      end
      if (w_in_win && w_full && !w_pop) r_overflow <= 1'b1;
      if (MemWrite && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign overflow    = r_overflow;
  assign store_count = r_count;

endmodule

// File: tb/tb_mmio_store_monitor.sv
// Directed bench for mmio_store_monitor in its default (non-bypass) build.
module tb_mmio_store_monitor;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_offset;
  logic [31:0] out_data;
  logic        done;
  logic        pass;
  logic        overflow;
  logic [15:0] store_count;

  int n_tests;
  int n_fail;

  mmio_store_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite    (MemWrite),
    .Adr         (Adr),
    .WriteData   (WriteData),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_offset  (out_offset),
    .out_data    (out_data),
    .done        (done),
    .pass        (pass),
    .overflow    (overflow),
    .store_count (store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Adr       = a;
    WriteData = d;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    MemWrite = 1'b0; Adr = '0; WriteData = '0; out_ready = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({out_valid, out_offset, out_data, done, pass, overflow, store_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got v=%b off=%0d d=%h done=%b pass=%b ovf=%b cnt=%0d, want all 0",
               out_valid, out_offset, out_data, done, pass, overflow, store_count);
    end
    reset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (out_valid !== 1'b0 || store_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_release: got v=%b cnt=%0d, want v=0 cnt=0", out_valid, store_count);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    store(32'd96, 32'hA);
    n_tests++;
    if (out_valid !== 1'b1 || out_offset !== 3'd0 || out_data !== 32'hA || store_count !== 16'd1) begin
      n_fail++;
      $display("FAIL single_visible: got v=%b off=%0d d=%h cnt=%0d, want v=1 off=0 d=a cnt=1",
               out_valid, out_offset, out_data, store_count);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_popped: got v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_done();
    out_ready = 1'b1;
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_before: got done=%b, want 0", done);
    end
    store(32'd100, 32'd7);
    n_tests++;
    if (done !== 1'b1 || pass !== 1'b1 || out_valid !== 1'b1 || out_offset !== 3'd1 || out_data !== 32'd7) begin
      n_fail++;
      $display("FAIL done_first: got done=%b pass=%b v=%b off=%0d d=%0d, want 1 1 1 1 7",
               done, pass, out_valid, out_offset, out_data);
    end
    tick();
    store(32'd100, 32'd3);
    n_tests++;
    if (done !== 1'b1 || pass !== 1'b1 || out_offset !== 3'd1 || out_data !== 32'd3 || store_count !== 16'd3) begin
      n_fail++;
      $display("FAIL done_sticky: got done=%b pass=%b off=%0d d=%0d cnt=%0d, want 1 1 1 3 3",
               done, pass, out_offset, out_data, store_count);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [31:0] adrs [5];
    adrs[0] = 32'h60; adrs[1] = 32'h68; adrs[2] = 32'h6C; adrs[3] = 32'h70; adrs[4] = 32'h74;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      MemWrite = 1'b1; Adr = adrs[i]; WriteData = 32'd11 + i;
      tick();
      if (i == 3) begin
        n_tests++;
        if (overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_early: got ovf=%b after 4 pushes, want 0", overflow);
        end
      end
    end
    MemWrite = 1'b0;
    n_tests++;
    if (overflow !== 1'b1 || store_count !== 16'd8 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got ovf=%b cnt=%0d v=%b, want 1 8 1", overflow, store_count, out_valid);
    end
    tick();
    n_tests++;
    if (out_data !== 32'd11 || out_offset !== 3'd0) begin
      n_fail++;
      $display("FAIL ovf_hold: got off=%0d d=%0d with ready=0, want 0 11", out_offset, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 32'd11 + i || out_offset !== adrs[i][4:2]) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: got v=%b off=%0d d=%0d, want 1 %0d %0d",
                 i, out_valid, out_offset, out_data, adrs[i][4:2], 11 + i);
      end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_empty: got v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_full_push_pop();
    reset_pulse();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      MemWrite = 1'b1; Adr = 32'h60 + 4 * i; WriteData = 32'd21 + i;
      tick();
    end
    MemWrite = 1'b1; Adr = 32'h70; WriteData = 32'd25; out_ready = 1'b1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'd21) begin
      n_fail++;
      $display("FAIL full_head: got v=%b d=%0d, want 1 21", out_valid, out_data);
    end
    tick();
    MemWrite = 1'b0;
    n_tests++;
    if (overflow !== 1'b0 || store_count !== 16'd5) begin
      n_fail++;
      $display("FAIL full_noovf: got ovf=%b cnt=%0d, want 0 5", overflow, store_count);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 32'd22 + i || out_offset !== 3'(i + 1)) begin
        n_fail++;
        $display("FAIL full_drain%0d: got v=%b off=%0d d=%0d, want 1 %0d %0d",
                 i, out_valid, out_offset, out_data, i + 1, 22 + i);
      end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_empty: got v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_ignored_and_flush();
    reset_pulse();
    out_ready = 1'b1;
    store(32'h80, 32'h55);
    store(32'h61, 32'h66);
    n_tests++;
    if (out_valid !== 1'b0 || store_count !== 16'd2) begin
      n_fail++;
      $display("FAIL ignored: got v=%b cnt=%0d, want 0 2", out_valid, store_count);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'h60 + 4 * i, 32'd31 + i);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'd31) begin
      n_fail++;
      $display("FAIL flush_pre: got v=%b d=%0d, want 1 31", out_valid, out_data);
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || store_count !== 16'd0) begin
      n_fail++;
      $display("FAIL flush_async: got v=%b d=%0d cnt=%0d, want 0 0 0", out_valid, out_data, store_count);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    reset_pulse();
    out_ready = 1'b1;
    MemWrite = 1'b1; Adr = 32'h0; WriteData = 32'h0;
    repeat (65534) tick();
    n_tests++;
    if (store_count !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL sat_near: got cnt=%h, want fffe", store_count);
    end
    repeat (4) tick();
    MemWrite = 1'b0;
    n_tests++;
    if (store_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_hold: got cnt=%h, want ffff", store_count);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single();
    test_done();
    test_overflow();
    test_full_push_pop();
    test_ignored_and_flush();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
